// File: rtl/fpto_int_wb_pkg.sv
// Shared types for the FP-to-INT writeback stage.
// Mask encodings, the buffered entry layout and the mask derivation.
package fpto_int_wb_pkg;

   localparam logic [1:0] MASK_LO   = 2'b01;
   localparam logic [1:0] MASK_HI   = 2'b10;
   localparam logic [1:0] MASK_FULL = 2'b11;

   // Register index width held in each buffered entry.
   localparam int ENT_ADDR_W = 5;

   typedef struct packed {
      logic [ENT_ADDR_W-1:0] addr;
      logic [31:0]           data;
      logic [1:0]            mask;
   } ent_t;

   function automatic logic [1:0] derive_mask(
      input logic src_prec,
      input logic dst_prec,
      input logic dst_pos
   );
      logic [1:0] m;
      if (dst_prec)
         m = MASK_FULL;
      else if (!src_prec)
         m = MASK_FULL;
      else
         m = dst_pos ? MASK_HI : MASK_LO;
      return m;
   endfunction

endpackage

// File: rtl/fpto_int_wb_fifo.sv
// Entry buffer for the writeback stage: storage, wrap-bit pointers, head port.
// Tail modify port exists only when FPTO_INT_WB_MERGE_EN is defined.
module fpto_int_wb_fifo
   import fpto_int_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int PW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  ent_t          push_ent,
   input  logic          pop,
   output ent_t          head,
   output logic          empty,
   output logic          full,
   output logic [PW-1:0] occ
`ifdef FPTO_INT_WB_MERGE_EN
   ,
   output ent_t          tail,
   input  logic          mod_en,
   input  ent_t          mod_ent
`endif
);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   ent_t          mem_q [DEPTH];
   ent_t          mem_d [DEPTH];
   logic [AW-1:0] widx, ridx;

   assign widx = wptr_q[AW-1:0];
   assign ridx = rptr_q[AW-1:0];

`ifdef FPTO_INT_WB_MERGE_EN
   logic [AW-1:0] tidx;
   assign tidx = widx - AW'(1);
   assign tail = mem_q[tidx];
`endif

   always_comb begin
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      mem_d  = mem_q;
      if (push)
         mem_d[widx] = push_ent;
`ifdef FPTO_INT_WB_MERGE_EN
      else if (mod_en)
         mem_d[tidx] = mod_ent;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[ridx];
   assign empty = (wptr_q == rptr_q);
   assign full  = (widx == ridx) && (wptr_q[AW] != rptr_q[AW]);
   assign occ   = wptr_q - rptr_q;

endmodule

// File: rtl/fpto_int_wb.sv
// Writeback stage after the FP-to-INT converter: buffers results for the RF port.
// Optional same-register half merging enabled by FPTO_INT_WB_MERGE_EN.
module fpto_int_wb
   import fpto_int_wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = ENT_ADDR_W,
   parameter int CNT_W  = 16,
   localparam int OW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   input  logic [31:0]       in_data,
   input  logic              in_src_prec,
   input  logic              in_dst_prec,
   input  logic              in_dst_pos,
   input  logic [ADDR_W-1:0] in_dst_addr,
   output logic              wr_vld,
   input  logic              wr_rdy,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [1:0]        wr_mask,
   output logic [OW-1:0]     occ,
   output logic              ovf,
   input  logic              ovf_clr,
   output logic [CNT_W-1:0]  wr_cnt
);

   ent_t             in_ent, head;
   logic             empty, full, pop, push, drop, merge;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign in_ent.addr = ENT_ADDR_W'(in_dst_addr);
   assign in_ent.data = in_data;
   assign in_ent.mask = derive_mask(in_src_prec, in_dst_prec, in_dst_pos);

   assign pop = !empty && wr_rdy;

`ifdef FPTO_INT_WB_MERGE_EN
   ent_t tail, mod_ent;

   // Only the newest entry can absorb the other half, and never while it leaves.
   always_comb begin
      merge = in_vld
           && (in_ent.mask != MASK_FULL)
           && !empty
           && !(pop && occ == OW'(1))
           && (tail.addr == in_ent.addr)
           && (tail.mask == ~in_ent.mask);
      mod_ent      = tail;
      mod_ent.mask = MASK_FULL;
      if (in_ent.mask == MASK_HI)
         mod_ent.data[31:16] = in_data[31:16];
      else
         mod_ent.data[15:0] = in_data[15:0];
   end
`else
   assign merge = 1'b0;
`endif

   always_comb begin
      push  = in_vld && !merge && (!full || pop);
      drop  = in_vld && !merge && full && !pop;
      ovf_d = ovf_q;
      if (drop)
         ovf_d = 1'b1;
      else if (ovf_clr)
         ovf_d = 1'b0;
      cnt_d = cnt_q;
      if (pop && cnt_q != '1)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         cnt_q <= cnt_d;
      end
   end

   fpto_int_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_ent (in_ent),
      .pop      (pop),
      .head     (head),
      .empty    (empty),
      .full     (full),
      .occ      (occ)
`ifdef FPTO_INT_WB_MERGE_EN
      ,
      .tail     (tail),
      .mod_en   (merge),
      .mod_ent  (mod_ent)
`endif
   );

   assign wr_vld  = !empty;
   assign wr_addr = wr_vld ? ADDR_W'(head.addr) : '0;
   assign wr_data = wr_vld ? head.data : '0;
   assign wr_mask = wr_vld ? head.mask : '0;
   assign ovf     = ovf_q;
   assign wr_cnt  = cnt_q;

endmodule

// File: tb/tb_fpto_int_wb.sv
// Bench for fpto_int_wb: queue-based reference model plus directed literal checks.
// Honours FPTO_INT_WB_MERGE_EN when the design is built with it.
module tb_fpto_int_wb;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 16;
   localparam int OW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_vld;
   logic [31:0]       in_data;
   logic              in_src_prec, in_dst_prec, in_dst_pos;
   logic [ADDR_W-1:0] in_dst_addr;
   logic              wr_vld, wr_rdy;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [1:0]        wr_mask;
   logic [OW-1:0]     occ;
   logic              ovf, ovf_clr;
   logic [CNT_W-1:0]  wr_cnt;

   fpto_int_wb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data),
      .in_src_prec(in_src_prec), .in_dst_prec(in_dst_prec),
      .in_dst_pos(in_dst_pos), .in_dst_addr(in_dst_addr),
      .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_mask(wr_mask), .occ(occ), .ovf(ovf),
      .ovf_clr(ovf_clr), .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          addr;
      logic [31:0] data;
      logic [1:0]  mask;
   } m_t;

   m_t q[$];
   bit m_ovf;
   int m_cnt;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] m_mask(input logic s, input logic d,
                                         input logic p);
      if (d || !s) return 2'b11;
      return p ? 2'b10 : 2'b01;
   endfunction

   task automatic m_reset();
      q.delete();
      m_ovf = 0;
      m_cnt = 0;
   endtask

   task automatic model_edge();
      int         sz;
      bit         pop, mrg, drop;
      logic [1:0] mk;
      m_t         e;
      sz   = q.size();
      pop  = (sz > 0) && wr_rdy;
      mrg  = 0;
      drop = 0;
      mk   = m_mask(in_src_prec, in_dst_prec, in_dst_pos);
`ifdef FPTO_INT_WB_MERGE_EN
      if (in_vld && mk != 2'b11 && sz > 0 && !(pop && sz == 1)
          && q[sz-1].addr == int'(in_dst_addr)
          && q[sz-1].mask == (2'b11 ^ mk))
         mrg = 1;
`endif
      if (pop) begin
         void'(q.pop_front());
         if (m_cnt != (1 << CNT_W) - 1) m_cnt++;
      end
      if (in_vld) begin
         if (mrg) begin
            e = q[q.size()-1];
            if (mk == 2'b10) e.data[31:16] = in_data[31:16];
            else             e.data[15:0]  = in_data[15:0];
            e.mask = 2'b11;
            q[q.size()-1] = e;
         end else if (sz < DEPTH || pop) begin
            q.push_back('{addr: int'(in_dst_addr), data: in_data, mask: mk});
         end else begin
            drop = 1;
         end
      end
      if (drop)         m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
   endtask

   task automatic compare_all();
      m_t h;
      h = '{addr: 0, data: 32'h0, mask: 2'b00};
      if (q.size() > 0) h = q[0];
      chk("wr_vld",  wr_vld,  (q.size() > 0) ? 1 : 0);
      chk("wr_addr", wr_addr, h.addr);
      chk("wr_data", wr_data, h.data);
      chk("wr_mask", wr_mask, h.mask);
      chk("occ",     occ,     q.size());
      chk("ovf",     ovf,     m_ovf);
      chk("wr_cnt",  wr_cnt,  m_cnt);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_in(input logic v, input logic [31:0] d, input logic s,
                         input logic dp, input logic p, input int a);
      in_vld      = v;
      in_data     = d;
      in_src_prec = s;
      in_dst_prec = dp;
      in_dst_pos  = p;
      in_dst_addr = ADDR_W'(a);
   endtask

   task automatic drain();
      in_vld = 0;
      wr_rdy = 1;
      for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++) step();
      chk("drain_empty", occ, 0);
   endtask

   task automatic async_reset();
      in_vld = 0;
      #2 rst_n = 0;
      #1;
      m_reset();
      chk("rst_wr_vld", wr_vld, 0);
      chk("rst_occ",    occ,    0);
      chk("rst_wr_cnt", wr_cnt, 0);
      chk("rst_ovf",    ovf,    0);
      compare_all();
      #1 rst_n = 1;
   endtask

   initial begin
      rst_n   = 0;
      wr_rdy  = 0;
      ovf_clr = 0;
      set_in(0, 32'h0, 0, 0, 0, 0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_vld", wr_vld, 0);
      chk("reset_occ", occ, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_cnt", wr_cnt, 0);
      chk("reset_data", wr_data, 0);
      rst_n = 1;

      // first transaction
      wr_rdy = 1;
      set_in(1, 32'h0001_0002, 1, 1, 0, 3);
      step();
      chk("t1_vld",  wr_vld, 1);
      chk("t1_addr", wr_addr, 3);
      chk("t1_data", wr_data, 32'h0001_0002);
      chk("t1_mask", wr_mask, 2'b11);
      in_vld = 0;
      step();
      chk("t1_cnt", wr_cnt, 1);
      chk("t1_idle", wr_vld, 0);

      // mask derivation
      wr_rdy = 0;
      set_in(1, 32'h1111_2222, 1, 0, 1, 1);
      step();
      chk("mask_hi", wr_mask, 2'b10);
      drain();
      wr_rdy = 0;
      set_in(1, 32'h3333_4444, 1, 0, 0, 2);
      step();
      chk("mask_lo", wr_mask, 2'b01);
      drain();
      wr_rdy = 0;
      set_in(1, 32'h5555_6666, 0, 0, 1, 4);
      step();
      chk("mask_simd", wr_mask, 2'b11);
      drain();

      // backpressure and overflow
      wr_rdy = 0;
      for (int i = 0; i < 5; i++) begin
         set_in(1, 32'hA000_0000 + i, 1, 1, 0, 10 + i);
         step();
      end
      in_vld = 0;
      chk("bp_occ",  occ, 4);
      chk("bp_ovf",  ovf, 1);
      chk("bp_head", wr_addr, 10);
      wr_rdy = 1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_order", wr_addr, 10 + i);
         step();
      end
      chk("bp_ovf_hold", ovf, 1);
      ovf_clr = 1;
      step();
      ovf_clr = 0;
      chk("bp_ovf_clr", ovf, 0);

      // full plus simultaneous pop
      wr_rdy = 0;
      for (int i = 0; i < 4; i++) begin
         set_in(1, 32'hB000_0000 + i, 1, 1, 0, 20 + i);
         step();
      end
      set_in(1, 32'hB000_0004, 1, 1, 0, 24);
      wr_rdy = 1;
      step();
      chk("fp_occ", occ, 4);
      chk("fp_ovf", ovf, 0);
      chk("fp_head", wr_addr, 21);
      drain();

      // half merge
      wr_rdy = 0;
      set_in(1, 32'h0000_1234, 1, 0, 0, 7);
      step();
      set_in(1, 32'hABCD_0000, 1, 0, 1, 7);
      step();
      in_vld = 0;
`ifdef FPTO_INT_WB_MERGE_EN
      chk("mg_occ",  occ, 1);
      chk("mg_data", wr_data, 32'hABCD_1234);
      chk("mg_mask", wr_mask, 2'b11);
`else
      chk("mg_occ",  occ, 2);
      chk("mg_data", wr_data, 32'h0000_1234);
      chk("mg_mask", wr_mask, 2'b01);
`endif
      drain();

      // asynchronous reset mid-stream
      wr_rdy = 0;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 32'hC000_0000 + i, 1, 1, 0, 16 + i);
         step();
      end
      chk("mr_occ", occ, 3);
      async_reset();
      set_in(1, 32'hD00D_0001, 1, 1, 0, 21);
      step();
      in_vld = 0;
      chk("mr_first", wr_addr, 21);
      chk("mr_data",  wr_data, 32'hD00D_0001);
      drain();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) async_reset();
         set_in($urandom_range(0, 3) != 0, $urandom, 1'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 3));
         wr_rdy  = ($urandom_range(0, 9) < ((i / 200) % 2 ? 7 : 3));
         ovf_clr = ($urandom_range(0, 15) == 0);
         step();
      end
      ovf_clr = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fpto_int_wb.md
Name: fpto_int_wb

Overview:
- Writeback stage directly downstream of the FP-to-INT converter.
- Captures each converted result (32-bit word plus precision/position control) and derives a 16-bit-half write mask.
- Buffers results in a small FIFO and presents them to the register-file write port with a valid/ready handshake.
- The converter has no backpressure, so inputs arriving while the buffer is full are dropped and flagged.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 5, destination register address width.
- CNT_W, 16, width of the completed-write counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  1  converter result valid (the converter's result_vld).
- in_data  in  32  converter output word (the converter's out_reg).
- in_src_prec  in  1  0=16-bit source, 1=32-bit source.
- in_dst_prec  in  1  0=16-bit destination, 1=32-bit destination.
- in_dst_pos  in  1  0=low half, 1=high half; used only for single-half writes.
- in_dst_addr  in  ADDR_W  destination register index.
- wr_vld  out  1  write request to the register file.
- wr_rdy  in  1  register file accepts the write.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  32  write data.
- wr_mask  out  2  bit1=write [31:16], bit0=write [15:0].
- occ  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky: an input was dropped.
- ovf_clr  in  1  synchronous clear of ovf.
- wr_cnt  out  CNT_W  count of completed writes, saturating.

Behaviour:
- Mask derivation:
  - in_dst_prec=1 → 2'b11.
  - in_dst_prec=0 and in_src_prec=0 (subword-parallel, both halves) → 2'b11.
  - Otherwise in_dst_pos ? 2'b10 : 2'b01.
- Data is stored unmodified. Bits outside the mask are don't-care to the register file.
- Accept rule: in_vld accepted when !full, or when full and a pop happens in the same cycle (wr_vld&&wr_rdy).
- Drop rule: when in_vld arrives, full, and no pop in that cycle, the input is dropped and ovf is set the next cycle.
- ovf handling:
  - If ovf_clr and a new drop coincide, the set wins (ovf stays 1).
  - ovf_clr otherwise clears ovf next cycle.
- Latency: an input accepted in cycle N is visible on wr_vld at cycle N+1 at the earliest. There is no combinational in→wr path.
- Output presentation:
  - wr_vld = !empty.
  - wr_addr/wr_data/wr_mask come from the head entry and are forced to 0 when wr_vld=0.
  - Head fields are held stable while wr_vld&&!wr_rdy.
- Pop: wr_vld&&wr_rdy advances the read pointer and increments wr_cnt. wr_cnt saturates at all-ones.
- Pointers: read and write pointers are $clog2(DEPTH)+1 bits, including a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - Wrap-around is natural modulo.
- Simultaneous push and pop:
  - occ is unchanged.
  - On an empty FIFO, the push lands and wr_vld rises next cycle. No bypass.
- Ordering: writes leave in strict acceptance order, including same-address writes.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, occ, ovf and wr_cnt go to 0; wr_vld=0.
  - All outputs read 0.
  - Storage contents are not reset.
  - An in-flight handshake is abandoned.

Optional Feature:
- Macro: FPTO_INT_WB_MERGE_EN.
- With the macro, an input is coalesced into the most recently pushed entry (no new entry consumed) when all of the following hold:
  - the input mask is a single half;
  - the FIFO is non-empty;
  - that entry is not the head being popped this cycle;
  - its address equals in_dst_addr;
  - its mask is the complementary single half.
- Effect of a merge:
  - the entry mask becomes 2'b11;
  - only the input's half of the entry data is overwritten;
  - the merge is accepted even when full, and ovf is not set;
  - wr_cnt counts the merged write once.
- Without the macro, every accepted input occupies its own entry and no comparison logic exists.

Decomposition:
- Package fpto_int_wb_pkg:
  - mask constants MASK_LO=2'b01, MASK_HI=2'b10, MASK_FULL=2'b11;
  - packed entry struct {addr, data, mask};
  - mask-derivation function.
- One sub-module, fpto_int_wb_fifo:
  - DEPTH-entry storage and pointer logic;
  - head read port;
  - a tail-entry modify port, used only under FPTO_INT_WB_MERGE_EN.

Test Plan:
- Reset → in_vld=1, data=32'h0001_0002, src_prec=1, dst_prec=1, addr=3; wr_rdy=1 → next cycle wr_vld=1, addr=3, data=32'h00010002, mask=11; wr_cnt=1 after the pop.
- Single-half write: src_prec=1, dst_prec=0, dst_pos=1 → mask=10. Same with dst_pos=0 → mask=01. src_prec=0, dst_prec=0 → mask=11.
- Backpressure: wr_rdy=0, push 5 inputs at DEPTH=4 → occ=4; the 5th is dropped; ovf=1; head stays the first input. Then wr_rdy=1 → 4 writes in order; ovf holds until an ovf_clr pulse.
- Full-plus-pop: FIFO full with wr_rdy=1 and in_vld=1 in the same cycle → input accepted; occ stays 4; ovf stays 0.
- Reset mid-stream: occ=3, assert rst_n=0 asynchronously between edges → wr_vld, occ, wr_cnt and ovf go to 0 immediately; first post-reset write is the next new input.
- MERGE_EN: with wr_rdy=0, push {addr 7, mask 01, data 0000_1234} then {addr 7, mask 10, data ABCD_0000} → occ=1; wr_data=ABCD1234, mask=11. Without the macro → occ=2.
